// File: rtl/ro_sensor_pkg.sv
// ro_sensor_pkg: shared state encoding, default widths and width check for the ring-oscillator sensor path.
package ro_sensor_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam int DATA_W = 16;
  localparam int ACC_W = 24;
  function automatic bit acc_w_ok(input int acc_w, input int data_w, input int log2_n);
    return acc_w >= data_w + log2_n;
  endfunction
endpackage

// File: rtl/ro_minmax_tracker.sv
// ro_minmax_tracker: running unsigned min/max with a combinational view including the current value.
module ro_minmax_tracker #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              update,
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] min_nxt,
  output logic [DATA_W-1:0] max_nxt
);
  assign min_nxt = (update && value < min_val) ? value : min_val;
  assign max_nxt = (update && value > max_val) ? value : max_val;
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      min_val <= '1;
      max_val <= '0;
    end else begin
      min_val <= min_nxt;
      max_val <= max_nxt;
    end
  end
endmodule

// File: rtl/ro_sample_averager.sv
// ro_sample_averager: accumulates 2^LOG2_N oscillator counts and hands sum/mean/min/max over valid/ready.
module ro_sample_averager
  import ro_sensor_pkg::*;
#(
  parameter int DATA_W = ro_sensor_pkg::DATA_W,
  parameter int LOG2_N = 4,
  parameter int ACC_W  = ro_sensor_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic              sample_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_mean,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic              overrun,
  output logic              busy
);
  if (!acc_w_ok(ACC_W, DATA_W, LOG2_N) || LOG2_N < 1 || LOG2_N > 8) begin : g_bad_params
    $error("ro_sample_averager: need 1<=LOG2_N<=8 and ACC_W >= DATA_W+LOG2_N");
  end
  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [LOG2_N-1:0]  idx;
  logic [DATA_W-1:0]  run_min, run_max, min_nxt, max_nxt;
  logic               accept, last, start, restart;
  logic [ACC_W-1:0]   acc_nxt;
  assign sample_ready = state == ACCUM;
  assign busy         = state != IDLE;
  assign accept       = sample_ready && sample_valid;
  assign last         = accept && idx == '1;
  assign acc_nxt      = acc + ACC_W'(sample);
  assign start        = state == IDLE && en;
  assign restart      = state == HOLD && out_ready && en;
  ro_minmax_tracker #(.DATA_W(DATA_W)) u_minmax (
    .clk     (clk),
    .reset   (reset),
    .clear   (start || restart),
    .update  (accept),
    .value   (sample),
    .min_val (run_min),
    .max_val (run_max),
    .min_nxt (min_nxt),
    .max_nxt (max_nxt)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_mean  <= '0;
      out_min   <= '0;
      out_max   <= '0;
      overrun   <= 1'b0;
    end else begin
      if (en && sample_valid && !sample_ready) overrun <= 1'b1;
      if (accept) begin
        acc <= acc_nxt;
        idx <= idx + 1'b1;
      end
      case (state)
        IDLE: if (en) begin
          state   <= ACCUM;
          acc     <= '0;
          idx     <= '0;
          overrun <= 1'b0;
        end
        ACCUM: if (last) begin
          state     <= HOLD;
          out_valid <= 1'b1;
          out_sum   <= acc_nxt;
          out_mean  <= DATA_W'(acc_nxt >> LOG2_N);
          out_min   <= min_nxt;
          out_max   <= max_nxt;
        end else if (!en) state <= IDLE;
        HOLD: if (out_ready) begin
          state     <= en ? ACCUM : IDLE;
          out_valid <= 1'b0;
          acc       <= '0;
          idx       <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
